ps2_key_decoder: RTL

// Receives PS/2 keyboard frames on keyClock/keyData and decodes set-2 make/break scancodes.

---
 rtl/ps2_key_decoder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard receiver: filtered clock, framed and parity-checked reception,
// make/break/extended decoding and held-key flags for the A/D/W/S game controls.
module ps2_key_decoder #(
    parameter int          FILTER_LEN  = 8,
    parameter int          TIMEOUT_CYC = 50000,
    parameter logic [7:0]  CODE_LEFT   = 8'h1C,
    parameter logic [7:0]  CODE_RIGHT  = 8'h23,
    parameter logic [7:0]  CODE_UP     = 8'h1D,
    parameter logic [7:0]  CODE_DOWN   = 8'h1B
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       keyClock,
    input  logic       keyData,
    output logic       left,
    output logic       right,
    output logic       up,
    output logic       down,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       code_break,
    output logic       code_ext,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic           clk_meta, clk_sync, data_meta, data_sync;
    logic           filt_clk, fall;
    logic [FCW-1:0] filt_cnt;

    state_t         state;
    logic [2:0]     bitcnt;
    logic [7:0]     shreg;
    logic           par_bit;
    logic [WDW-1:0] wdog;
    logic           ext_pend, brk_pend;

    // NOTE: every register here is assigned with <= so all blocks see pre-edge values.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= keyClock;
            clk_sync  <= clk_meta;
            data_meta <= keyData;
            data_sync <= data_meta;
        end
    end

    // A new clock level is accepted only after FILTER_LEN consecutive agreeing samples.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_sync;
                filt_cnt <= '0;
                fall     <= filt_clk;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state      <= IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            wdog       <= '0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            left       <= 1'b0;
            right      <= 1'b0;
            up         <= 1'b0;
            down       <= 1'b0;
            code       <= 8'h00;
            code_valid <= 1'b0;
            code_break <= 1'b0;
            code_ext   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                wdog <= '0;
                case (state)
                    IDLE: begin
                        if (!data_sync) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg  <= {data_sync, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_sync;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (data_sync && ^{shreg, par_bit}) begin
                            if (shreg == 8'hE0) begin
                                ext_pend <= 1'b1;
                            end else if (shreg == 8'hF0) begin
                                brk_pend <= 1'b1;
                            end else begin
                                code       <= shreg;
                                code_break <= brk_pend;
                                code_ext   <= ext_pend;
                                code_valid <= 1'b1;
                                ext_pend   <= 1'b0;
                                brk_pend   <= 1'b0;
                                // Extended codes share byte values with the game keys; ignore them.
                                if (!ext_pend) begin
                                    if (shreg == CODE_LEFT)  left  <= ~brk_pend;
                                    if (shreg == CODE_RIGHT) right <= ~brk_pend;
                                    if (shreg == CODE_UP)    up    <= ~brk_pend;
                                    if (shreg == CODE_DOWN)  down  <= ~brk_pend;
                                end
                            end
                        end else begin
                            frame_err <= 1'b1;
                            ext_pend  <= 1'b0;
                            brk_pend  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                // A stalled frame is abandoned so the next start bit resynchronises.
                if (wdog == WDW'(TIMEOUT_CYC - 1)) begin
                    state     <= IDLE;
                    wdog      <= '0;
                    frame_err <= 1'b1;
                    ext_pend  <= 1'b0;
                    brk_pend  <= 1'b0;
                end else begin
                    wdog <= wdog + 1'b1;
                end
            end
        end
    end

endmodule
